// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map offsets,
// FSM state encoding and the default register window base.
package irq_ctrl_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h0000_7F20;

    localparam logic [31:0] OFF_ACK     = 32'd0;
    localparam logic [31:0] OFF_MASK    = 32'd4;
    localparam logic [31:0] OFF_PENDING = 32'd8;
    localparam logic [31:0] OFF_EOI     = 32'd12;
    localparam logic [31:0] OFF_STATUS  = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit index of vec.
module irq_prio_enc #(
    parameter  int N  = 6,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-captured pending bits, mask, single-level
// request/service handshake with the CPU through a small register window.
// Optional acknowledge watchdog and STATUS register: IRQC_ACK_TIMEOUT_EN.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | no request outstanding, waiting for PENDING & MASK
// ST_REQ     | cpu_irq asserted with a frozen id, waiting for ACK
// ST_SERVICE | CPU is handling the interrupt, waiting for EOI
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NSRC        = 6,
    parameter logic [31:0] BASE        = DEFAULT_BASE,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [31:0]     reg_addr,
    input  logic [31:0]     reg_wdata,
    input  logic [3:0]      reg_byteen,
    input  logic            reg_re,
    output logic [31:0]     reg_rdata,
    output logic            cpu_irq,
    output logic [2:0]      cpu_irq_id,
    output logic            busy
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    irq_state_e      state_q, state_nx;
    logic [NSRC-1:0] src_q, pending_q, mask_q;
    logic [NSRC-1:0] edge_set, lane_bits, w1c_clr, ack_clr;
    logic [NSRC-1:0] pending_nx, mask_nx, req_vec;
    logic            first_q;
    logic [2:0]      irq_id_q;
    logic [IW-1:0]   enc_idx;
    logic            enc_valid;
    logic            wr_en, ack_wr, eoi_wr, mask_wr, pend_wr, status_wr;
    logic            src_live, tmo_fire;
    logic [31:0]     status_rd, rdata_nx;
    logic            unused_ok;

    assign unused_ok = ^{reg_wdata[31:NSRC], 32'(ACK_TIMEOUT)};

    // Register write decode; ACK and EOI accept any nonzero byte enable.
    always_comb begin
        wr_en     = |reg_byteen;
        ack_wr    = wr_en && (reg_addr == BASE + OFF_ACK);
        mask_wr   = wr_en && (reg_addr == BASE + OFF_MASK);
        pend_wr   = wr_en && (reg_addr == BASE + OFF_PENDING);
        eoi_wr    = wr_en && (reg_addr == BASE + OFF_EOI);
        status_wr = wr_en && (reg_addr == BASE + OFF_STATUS);
        for (int i = 0; i < NSRC; i++) lane_bits[i] = reg_byteen[i/8];
    end

    // Next PENDING / MASK values; a fresh edge overrides any clear.
    always_comb begin
        edge_set   = first_q ? '0 : (irq_src & ~src_q);
        w1c_clr    = pend_wr ? (reg_wdata[NSRC-1:0] & lane_bits) : '0;
        ack_clr    = (ack_wr && state_q == ST_REQ) ? (NSRC'(1) << irq_id_q) : '0;
        pending_nx = (pending_q & ~w1c_clr & ~ack_clr) | edge_set;
        mask_nx    = mask_wr ? ((mask_q & ~lane_bits) | (reg_wdata[NSRC-1:0] & lane_bits))
                             : mask_q;
        src_live   = pending_nx[irq_id_q] & mask_nx[irq_id_q];
        req_vec    = pending_q & mask_q;
    end

    irq_prio_enc #(.N(NSRC)) u_prio (
        .vec   (req_vec),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Edge-detect history, PENDING and MASK; the first cycle out of reset
    // only loads history so lines held high through reset raise no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            first_q   <= 1'b1;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            src_q     <= irq_src;
            first_q   <= 1'b0;
            pending_q <= pending_nx;
            mask_q    <= mask_nx;
        end
    end

`ifdef IRQC_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT) + 1;

    logic [CW-1:0] tmo_cnt_q;
    logic          status_q;

    assign tmo_fire  = (state_q == ST_REQ) && (tmo_cnt_q == '0) && !ack_wr && src_live;
    assign status_rd = {31'b0, status_q};

    // Down-counter loaded on REQ entry; terminal count ends the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_IDLE && state_nx == ST_REQ) begin
            tmo_cnt_q <= CW'(ACK_TIMEOUT - 1);
        end else if (state_q == ST_REQ && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= 1'b0;
        end else if (tmo_fire) begin
            status_q <= 1'b1;
        end else if (status_wr && reg_byteen[0] && reg_wdata[0]) begin
            status_q <= 1'b0;
        end
    end
`else
    logic unused_status;

    assign unused_status = status_wr;
    assign tmo_fire      = 1'b0;
    assign status_rd     = '0;
`endif

    // Next-state logic for the request/service handshake.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (ack_wr)                    state_nx = ST_SERVICE;
                else if (!src_live || tmo_fire) state_nx = ST_IDLE;
            end
            ST_SERVICE: begin
                if (eoi_wr) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register and id latch; the id only moves on IDLE->REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            irq_id_q <= '0;
        end else begin
            state_q <= state_nx;
            if (state_q == ST_IDLE && enc_valid) irq_id_q <= 3'(enc_idx);
        end
    end

    // Read mux for the register window; unmapped offsets read as zero.
    always_comb begin
        rdata_nx = '0;
        if (reg_re) begin
            case (reg_addr)
                BASE + OFF_MASK:    rdata_nx = 32'(mask_q);
                BASE + OFF_PENDING: rdata_nx = 32'(pending_q);
                BASE + OFF_STATUS:  rdata_nx = status_rd;
                default:            rdata_nx = '0;
            endcase
        end
    end

    // Read data is registered and returns to zero when no read was issued.
    always_ff @(posedge clk) begin
        if (reset) reg_rdata <= '0;
        else       reg_rdata <= rdata_nx;
    end

    assign cpu_irq    = (state_q == ST_REQ);
    assign busy       = (state_q == ST_SERVICE);
    assign cpu_irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a cycle model built from the register/handshake rules
// is compared against the DUT every cycle, plus directed literal checks.
module tb_irq_ctrl;

    localparam int          NSRC = 6;
    localparam logic [31:0] BASE = 32'h7F20;
    localparam int          TMO  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  irq_src = '0;
    logic [31:0] reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [3:0]  reg_byteen = '0;
    logic        reg_re = 1'b0;
    logic [31:0] reg_rdata;
    logic        cpu_irq;
    logic [2:0]  cpu_irq_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NSRC(NSRC), .BASE(BASE), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_byteen (reg_byteen),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .cpu_irq    (cpu_irq),
        .cpu_irq_id (cpu_irq_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [5:0]  m_pend, m_mask, m_hist;
    bit        m_first, m_req, m_svc, m_status, m_live;
    int        m_id, m_tmr;
    bit [31:0] m_rdata;

    function automatic int lowest(input bit [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        bit [5:0] e, lane, clr, npend, nmask;
        bit       wr, ack, eoi, nstat;
        if (reset) begin
            m_pend <= '0; m_mask <= '0; m_hist <= '0; m_first <= 1'b1;
            m_req <= 1'b0; m_svc <= 1'b0; m_status <= 1'b0; m_id <= 0;
            m_tmr <= 0; m_rdata <= '0; m_live <= 1'b1;
        end else begin
            e  = m_first ? 6'h00 : (irq_src & ~m_hist);
            wr = (reg_byteen != 4'h0);
            for (int i = 0; i < 6; i++) lane[i] = reg_byteen[i/8];
            ack   = wr && reg_addr == BASE;
            eoi   = wr && reg_addr == BASE + 12;
            nmask = (wr && reg_addr == BASE + 4) ? ((m_mask & ~lane) | (reg_wdata[5:0] & lane)) : m_mask;
            clr   = (wr && reg_addr == BASE + 8) ? (reg_wdata[5:0] & lane) : 6'h00;
            if (ack && m_req) clr[m_id] = 1'b1;
            npend = (m_pend & ~clr) | e;
            nstat = m_status;
            if (wr && reg_addr == BASE + 16 && reg_byteen[0] && reg_wdata[0]) nstat = 1'b0;

            m_rdata <= '0;
            if (reg_re) begin
                if (reg_addr == BASE + 4)  m_rdata <= 32'(m_mask);
                if (reg_addr == BASE + 8)  m_rdata <= 32'(m_pend);
`ifdef IRQC_ACK_TIMEOUT_EN
                if (reg_addr == BASE + 16) m_rdata <= 32'(m_status);
`endif
            end

            if (!m_req && !m_svc) begin
                if ((m_pend & m_mask) != 6'h00) begin
                    m_req <= 1'b1;
                    m_id  <= lowest(m_pend & m_mask);
                    m_tmr <= 0;
                end
            end else if (m_req) begin
                if (ack) begin
                    m_req <= 1'b0;
                    m_svc <= 1'b1;
                end else if (!(npend[m_id] && nmask[m_id])) begin
                    m_req <= 1'b0;
`ifdef IRQC_ACK_TIMEOUT_EN
                end else if (m_tmr + 1 == TMO) begin
                    m_req <= 1'b0;
                    nstat = 1'b1;
                end else begin
                    m_tmr <= m_tmr + 1;
`endif
                end
            end else if (eoi) begin
                m_svc <= 1'b0;
            end

            m_pend   <= npend;
            m_mask   <= nmask;
            m_hist   <= irq_src;
            m_first  <= 1'b0;
            m_status <= nstat;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_cpu_irq", 32'(cpu_irq), 32'(m_req));
            check("cyc_busy", 32'(busy), 32'(m_svc));
            check("cyc_irq_id", 32'(cpu_irq_id), 32'(m_id));
            check("cyc_rdata", reg_rdata, m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_addr = a; reg_wdata = d; reg_byteen = be;
        @(negedge clk);
        reg_byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        reg_addr = a; reg_re = 1'b1;
        @(negedge clk);
        reg_re = 1'b0;
        check(name, reg_rdata, exp);
    endtask

    task automatic pulse(input logic [5:0] m);
        irq_src = irq_src | m;
        @(negedge clk);
        irq_src = irq_src & ~m;
    endtask

    initial begin
        int n;
        @(negedge clk);
        cyc(3);
        check("rst_cpu_irq", 32'(cpu_irq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_id", 32'(cpu_irq_id), 0);
        check("rst_rdata", reg_rdata, 0);
        reset = 1'b0;
        cyc(2);

        // single source, full handshake
        wr(BASE + 4, 32'h3F, 4'h1);
        pulse(6'h04);
        rd(BASE + 8, 32'h04, "pend_src2");
        check("req_irq_src2", 32'(cpu_irq), 1);
        check("req_id_src2", 32'(cpu_irq_id), 2);
        wr(BASE, 32'h0, 4'h1);
        check("ack_busy", 32'(busy), 1);
        check("ack_irq_low", 32'(cpu_irq), 0);
        wr(BASE + 12, 32'h0, 4'h8);
        check("eoi_busy", 32'(busy), 0);

        // two simultaneous sources: priority, ACK clear, re-request after EOI
        pulse(6'h12);
        cyc(1);
        check("prio_id1", 32'(cpu_irq_id), 1);
        wr(BASE, 32'h0, 4'h1);
        rd(BASE + 8, 32'h10, "pend_after_ack");
        check("svc_busy", 32'(busy), 1);
        wr(BASE + 12, 32'h0, 4'h1);
        check("eoi_idle", 32'(cpu_irq), 0);
        cyc(1);
        check("rereq_irq", 32'(cpu_irq), 1);
        check("rereq_id4", 32'(cpu_irq_id), 4);
        wr(BASE, 32'h0, 4'h1);
        wr(BASE + 12, 32'h0, 4'h1);

        // masked source stays pending until unmasked
        wr(BASE + 4, 32'h0, 4'h1);
        pulse(6'h01);
        rd(BASE + 8, 32'h01, "pend_masked");
        cyc(2);
        check("masked_no_irq", 32'(cpu_irq), 0);
        wr(BASE + 4, 32'h1, 4'h1);
        cyc(1);
        check("unmask_irq", 32'(cpu_irq), 1);
        check("unmask_id0", 32'(cpu_irq_id), 0);
        wr(BASE, 32'h0, 4'h1);
        wr(BASE + 12, 32'h0, 4'h1);

        // W1C of the latched source withdraws the request; late ACK ignored
        wr(BASE + 4, 32'h3F, 4'h1);
        pulse(6'h08);
        cyc(1);
        check("req_id3", 32'(cpu_irq_id), 3);
        wr(BASE + 8, 32'h08, 4'h1);
        check("w1c_irq_drop", 32'(cpu_irq), 0);
        wr(BASE, 32'h0, 4'h1);
        check("late_ack_busy", 32'(busy), 0);
        rd(BASE + 8, 32'h00, "pend_w1c");
        wr(BASE + 4, 32'h0, 4'h2);
        rd(BASE + 4, 32'h3F, "mask_lane1_noeffect");

        // edge coincident with W1C of the same bit: set wins
        irq_src = 6'h20;
        reg_addr = BASE + 8; reg_wdata = 32'h20; reg_byteen = 4'h1;
        @(negedge clk);
        reg_byteen = 4'h0; irq_src = 6'h00;
        rd(BASE + 8, 32'h20, "edge_beats_w1c");
        check("req_id5", 32'(cpu_irq_id), 5);
        wr(BASE, 32'h0, 4'h1);
        check("svc5_busy", 32'(busy), 1);

        // reset during SERVICE with a line held high through reset
        irq_src = 6'h01;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_irq", 32'(cpu_irq), 0);
        check("midrst_id", 32'(cpu_irq_id), 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check("held_no_irq", 32'(cpu_irq), 0);
        rd(BASE + 8, 32'h00, "held_no_edge");
        rd(BASE + 4, 32'h00, "mask_after_rst");
        rd(BASE + 16, 32'h00, "status_clear");
        rd(BASE + 20, 32'h00, "unmapped_read");

`ifdef IRQC_ACK_TIMEOUT_EN
        wr(BASE + 4, 32'h3F, 4'h1);
        pulse(6'h02);
        cyc(1);
        n = 0;
        while (cpu_irq === 1'b1 && n < 300) begin
            n++;
            cyc(1);
        end
        check("tmo_req_cycles", 32'(n), 32'(TMO));
        check("tmo_irq_low", 32'(cpu_irq), 0);
        cyc(1);
        check("tmo_rereq", 32'(cpu_irq), 1);
        rd(BASE + 16, 32'h1, "status_set");
        wr(BASE + 16, 32'h1, 4'h1);
        rd(BASE + 16, 32'h0, "status_w1c");
        wr(BASE, 32'h0, 4'h1);
        wr(BASE + 12, 32'h0, 4'h1);
`else
        n = 0;
`endif
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameters: NSRC, default 6, number of interrupt sources; BASE, default 32'h7F20, register window base address; ACK_TIMEOUT, default 64, cycles allowed for CPU acknowledge.
REQ-002 SHALL have ports, one per line:
  clk  in  1  rising-edge clock;
  reset  in  1  synchronous, active-high reset;
  irq_src  in  NSRC  raw interrupt lines, level, bit 0 highest priority;
  reg_addr  in  32  register access address, word aligned;
  reg_wdata  in  32  write data;
  reg_byteen  in  4  byte enables, nonzero = write;
  reg_re  in  1  read strobe;
  reg_rdata  out  32  read data;
  cpu_irq  out  1  interrupt request to core;
  cpu_irq_id  out  3  index of the requesting source;
  busy  out  1  high while in SERVICE.

Function
REQ-003 SHALL decode four word registers: BASE+0 ACK (write only), BASE+4 MASK (rw, bits NSRC-1:0), BASE+8 PENDING (read; write-1-to-clear), BASE+12 EOI (write only); other addresses ignored, reads return 0.
REQ-004 SHALL treat a write as any cycle with reg_byteen != 0 and the address in the window; byte lanes apply to MASK and PENDING, while ACK and EOI act on any nonzero byteen.
REQ-005 SHALL register reg_rdata one cycle after reg_re; reg_rdata SHALL be 0 in cycles without a preceding reg_re.
REQ-006 SHALL set PENDING[i] on a 0->1 edge of irq_src[i], using a one-cycle registered edge detector.
REQ-007 SHALL let a same-cycle edge set win over a W1C clear or an ACK clear of the same bit.
REQ-008 SHALL run the FSM IDLE -> REQ -> SERVICE -> IDLE:
  IDLE->REQ when (PENDING & MASK) != 0;
  REQ->SERVICE on an ACK write;
  SERVICE->IDLE on an EOI write.
REQ-009 SHALL, on IDLE->REQ, latch cpu_irq_id to the lowest set index of PENDING & MASK; the id is frozen until the state leaves REQ.
REQ-010 SHALL drive cpu_irq = 1 exactly while in REQ, registered.
REQ-011 SHALL, on ACK in REQ, clear PENDING[cpu_irq_id] in the same edge.
REQ-012 SHALL ignore ACK outside REQ and EOI outside SERVICE.
REQ-013 SHALL, if the latched source is masked or cleared by W1C while in REQ, return to IDLE the next cycle with cpu_irq = 0.
REQ-014 SHALL hold new edges pending during SERVICE; no preemption or nesting.
REQ-015 SHALL drive busy = 1 exactly in SERVICE.

Reset
REQ-016 SHALL, on reset, force: state IDLE; PENDING 0; MASK 0; edge-detect history 0; cpu_irq 0; cpu_irq_id 0; busy 0; reg_rdata 0; timeout counter 0.
REQ-017 SHALL give reset priority over every write, edge and FSM transition, including mid-REQ or mid-SERVICE.
REQ-018 SHALL treat irq_src held high through reset as already seen: no edge after reset release.

Configuration
REQ-019 SHALL compile the acknowledge watchdog only when IRQC_ACK_TIMEOUT_EN is defined.
REQ-020 SHALL, with IRQC_ACK_TIMEOUT_EN:
  count cycles in REQ;
  when the count reaches ACK_TIMEOUT without ACK, return to IDLE, keep PENDING unchanged and set sticky STATUS bit 0;
  read STATUS at BASE+16; clear it by writing 1 to bit 0.
REQ-021 SHALL, without IRQC_ACK_TIMEOUT_EN, have no counter; REQ waits indefinitely and BASE+16 reads 0.

Structure
REQ-022 SHALL take register offsets, the FSM state enum and the default BASE from shared package irq_ctrl_pkg.
REQ-023 SHALL place priority selection in sub-module irq_prio_enc (NSRC-bit vector in; index plus valid out; combinational).

Verification
REQ-024 Reset, MASK=6'h3F, pulse irq_src[2] -> PENDING=6'h04 one cycle after the edge; cpu_irq=1 and cpu_irq_id=2 on the next edge.
REQ-025 Pulse irq_src[4] and irq_src[1] in the same cycle -> cpu_irq_id=1; ACK write to 32'h7F20 with byteen 4'h1 -> PENDING=6'h10 and busy=1; EOI -> IDLE, then a new REQ with id 4.
REQ-026 MASK=0, pulse irq_src[0] -> PENDING=6'h01 and cpu_irq stays 0; then write MASK=1 -> cpu_irq=1.
REQ-027 In REQ with id 3, W1C PENDING=6'h08 -> cpu_irq=0 next cycle and state IDLE; an ACK the following cycle is ignored.
REQ-028 irq_src[5] edge coincident with a W1C of bit 5 -> PENDING[5]=1; assert reset during SERVICE -> all outputs 0 next cycle.
REQ-029 With IRQC_ACK_TIMEOUT_EN and ACK_TIMEOUT=64, no ACK -> cpu_irq drops after 64 REQ cycles and STATUS reads 1; REQ then re-enters on the next cycle because PENDING still holds the bit.
